// File: rtl/io_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter_pkg
// Shared types and constants for the motion-system register bus arbiter:
// the arbiter FSM state encoding, default bus geometry, address/data
// typedefs and a helper that sizes master-index fields.
// -----------------------------------------------------------------------------
package io_bus_arbiter_pkg;

    // Number of masters on the motion-system bus; index 0 is uP_interface.
    localparam int NOS_BUS_MASTERS = 2;
    localparam int BUS_ADDR_W      = 8;
    localparam int BUS_DATA_W      = 32;
    localparam int BUS_TIMEOUT     = 64;

    typedef logic [BUS_ADDR_W-1:0] bus_addr_t;
    typedef logic [BUS_DATA_W-1:0] bus_data_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Width of a field holding a master index; never narrower than one bit.
    function automatic int arb_idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches the request vector upward
// starting one past the most recently served master, wrapping modulo N,
// and reports the first requester found.
//   req    : per-master request vector
//   last   : index of the master served most recently
//   winner : one-hot selected master (zero when nobody requests)
//   any    : at least one request is pending
// -----------------------------------------------------------------------------
module rr_picker
    import io_bus_arbiter_pkg::*;
#(
    parameter int N = NOS_BUS_MASTERS,
    parameter int W = arb_idx_w(NOS_BUS_MASTERS)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] winner,
    output logic         any
);

    logic [W-1:0] idx;
    logic         found;

    // Rotating search: the just-served master is examined last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(last) + i) % N);
            if (req[idx] && !found) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end else begin
                found = found;
            end
        end
        any = found;
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
// Round-robin arbiter sharing the motion-system register bus between the
// uP_interface command path (master 0) and autonomous masters. One master
// is granted at a time; its transaction is driven on the bus until the
// addressed slave acknowledges or the BUSY timeout expires.
//   clk        : system clock
//   reset      : synchronous active-low reset
//   m_req      : per-master request, held until m_done
//   m_addr     : per-master address
//   m_wdata    : per-master write data
//   m_rnw      : per-master direction (1 = read)
//   m_grant    : one-hot grant, zero when no transaction is active
//   m_done     : one-cycle completion pulse to the served master
//   m_err      : one-cycle timeout pulse, coincident with m_done
//   m_rdata    : read data captured from the bus, shared by all masters
//   bus_valid  : transaction active on the bus
//   bus_addr   : address of the granted master
//   bus_wdata  : write data of the granted master
//   bus_rnw    : direction of the granted master
//   bus_ack    : slave acknowledge (pulse or level)
//   bus_rdata  : slave read data, valid with bus_ack
// -----------------------------------------------------------------------------
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NOS_MASTERS = NOS_BUS_MASTERS,
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DATA_W      = BUS_DATA_W,
    parameter int TIMEOUT     = BUS_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NOS_MASTERS-1:0]             m_req,
    input  logic [NOS_MASTERS-1:0][ADDR_W-1:0] m_addr,
    input  logic [NOS_MASTERS-1:0][DATA_W-1:0] m_wdata,
    input  logic [NOS_MASTERS-1:0]             m_rnw,
    output logic [NOS_MASTERS-1:0]             m_grant,
    output logic [NOS_MASTERS-1:0]             m_done,
    output logic [NOS_MASTERS-1:0]             m_err,
    output logic [DATA_W-1:0]                  m_rdata,
    output logic                               bus_valid,
    output logic [ADDR_W-1:0]                  bus_addr,
    output logic [DATA_W-1:0]                  bus_wdata,
    output logic                               bus_rnw,
    input  logic                               bus_ack,
    input  logic [DATA_W-1:0]                  bus_rdata
);

    localparam int         LAST_W    = arb_idx_w(NOS_MASTERS);
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    arb_state_t               state_r;
    logic [LAST_W-1:0]        last_r;
    logic [7:0]               cnt_r;
    logic [NOS_MASTERS-1:0]   winner_s;
    logic                     any_s;
    logic [LAST_W-1:0]        winner_idx_s;

    rr_picker #(
        .N (NOS_MASTERS),
        .W (LAST_W)
    ) u_rr_picker (
        .req    (m_req),
        .last   (last_r),
        .winner (winner_s),
        .any    (any_s)
    );

    // Encode the one-hot winner into the index stored as the new "last".
    always_comb begin
        winner_idx_s = '0;
        for (int i = 0; i < NOS_MASTERS; i++) begin
            winner_idx_s = winner_idx_s | (LAST_W'(i) & {LAST_W{winner_s[i]}});
        end
    end

    // AND-OR bus mux steered by the registered grant; all zero when no grant.
    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_rnw   = 1'b0;
        for (int i = 0; i < NOS_MASTERS; i++) begin
            bus_addr  = bus_addr  | ({ADDR_W{m_grant[i]}} & m_addr[i]);
            bus_wdata = bus_wdata | ({DATA_W{m_grant[i]}} & m_wdata[i]);
            bus_rnw   = bus_rnw   | (m_grant[i] & m_rnw[i]);
        end
    end

    // Arbiter FSM with timeout counter and registered master-side outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // last = NOS_MASTERS-1 so that master 0 wins the first arbitration.
            state_r   <= ARB_IDLE;
            last_r    <= LAST_W'(NOS_MASTERS - 1);
            cnt_r     <= 8'd0;
            m_grant   <= '0;
            m_done    <= '0;
            m_err     <= '0;
            m_rdata   <= '0;
            bus_valid <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    m_done <= '0;
                    m_err  <= '0;
                    if (any_s) begin
                        m_grant   <= winner_s;
                        last_r    <= winner_idx_s;
                        cnt_r     <= 8'd0;
                        bus_valid <= 1'b1;
                        state_r   <= ARB_BUSY;
                    end else begin
                        m_grant   <= '0;
                        bus_valid <= 1'b0;
                    end
                end
                ARB_BUSY: begin
                    // Ack is checked first so an ack on the limit cycle wins.
                    if (bus_ack) begin
                        if (bus_rnw) begin
                            m_rdata <= bus_rdata;
                        end else begin
                            m_rdata <= m_rdata;
                        end
                        m_done    <= m_grant;
                        m_err     <= '0;
                        m_grant   <= '0;
                        bus_valid <= 1'b0;
                        state_r   <= ARB_RELEASE;
                    end else if (cnt_r == CNT_LIMIT) begin
                        m_done    <= m_grant;
                        m_err     <= m_grant;
                        m_grant   <= '0;
                        bus_valid <= 1'b0;
                        state_r   <= ARB_RELEASE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ARB_RELEASE: begin
                    // Requests and late acks are ignored for this cycle.
                    m_done    <= '0;
                    m_err     <= '0;
                    m_grant   <= '0;
                    bus_valid <= 1'b0;
                    state_r   <= ARB_IDLE;
                end
                default: begin
                    m_done    <= '0;
                    m_err     <= '0;
                    m_grant   <= '0;
                    bus_valid <= 1'b0;
                    state_r   <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arbiter
// Directed self-checking bench for io_bus_arbiter (2 masters, TIMEOUT = 64).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_io_bus_arbiter;

    logic             clk;
    logic             reset;
    logic [1:0]       m_req;
    logic [1:0][7:0]  m_addr;
    logic [1:0][31:0] m_wdata;
    logic [1:0]       m_rnw;
    logic [1:0]       m_grant;
    logic [1:0]       m_done;
    logic [1:0]       m_err;
    logic [31:0]      m_rdata;
    logic             bus_valid;
    logic [7:0]       bus_addr;
    logic [31:0]      bus_wdata;
    logic             bus_rnw;
    logic             bus_ack;
    logic [31:0]      bus_rdata;

    int checks;
    int errors;

    io_bus_arbiter #(
        .NOS_MASTERS (2),
        .ADDR_W      (8),
        .DATA_W      (32),
        .TIMEOUT     (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rnw     (m_rnw),
        .m_grant   (m_grant),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rnw   (bus_rnw),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        m_req     = 2'b00;
        m_addr    = '0;
        m_wdata   = '0;
        m_rnw     = 2'b00;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        step();
        step();
        checks++; if (m_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", m_grant); end
        checks++; if (m_done !== 2'b00 || m_err !== 2'b00) begin errors++; $display("FAIL reset_done_err got %b/%b want 00/00", m_done, m_err); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", m_rdata); end
        checks++; if (bus_valid !== 1'b0 || bus_addr !== 8'h0 || bus_wdata !== 32'h0 || bus_rnw !== 1'b0) begin
            errors++; $display("FAIL reset_bus got v=%b a=%h d=%h r=%b want all 0", bus_valid, bus_addr, bus_wdata, bus_rnw); end
        reset = 1'b1;
    endtask

    task automatic test_write();
        m_req      = 2'b01;
        m_addr[0]  = 8'h10;
        m_wdata[0] = 32'h0000_1234;
        m_rnw[0]   = 1'b0;
        step();
        checks++; if (m_grant !== 2'b01 || bus_valid !== 1'b1) begin errors++; $display("FAIL wr_grant got %b v=%b want 01 v=1", m_grant, bus_valid); end
        checks++; if (bus_addr !== 8'h10 || bus_wdata !== 32'h0000_1234 || bus_rnw !== 1'b0) begin
            errors++; $display("FAIL wr_bus got %h/%h/%b want 10/00001234/0", bus_addr, bus_wdata, bus_rnw); end
        step();
        checks++; if (m_grant !== 2'b01 || m_done !== 2'b00) begin errors++; $display("FAIL wr_busy2 got g=%b d=%b want g=01 d=00", m_grant, m_done); end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        m_req   = 2'b00;
        checks++; if (m_done !== 2'b01 || m_err !== 2'b00) begin errors++; $display("FAIL wr_done got d=%b e=%b want 01/00", m_done, m_err); end
        checks++; if (m_grant !== 2'b00 || bus_valid !== 1'b0) begin errors++; $display("FAIL wr_release got g=%b v=%b want 00/0", m_grant, bus_valid); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", m_rdata); end
        step();
        checks++; if (m_done !== 2'b00) begin errors++; $display("FAIL wr_done_pulse got %b want 00", m_done); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_grant [9];
        logic [1:0] exp_done  [9];
        exp_grant = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        exp_done  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        reset = 1'b0;
        step();
        reset      = 1'b1;
        m_req      = 2'b11;
        m_addr[1]  = 8'h20;
        m_wdata[1] = 32'h0000_0BB0;
        m_rnw[1]   = 1'b0;
        bus_ack    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++; if (m_grant !== exp_grant[i]) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", i, m_grant, exp_grant[i]); end
            checks++; if (m_done !== exp_done[i]) begin errors++; $display("FAIL rr_done[%0d] got %b want %b", i, m_done, exp_done[i]); end
            checks++; if (bus_valid !== (exp_grant[i] != 2'b00)) begin errors++; $display("FAIL rr_valid[%0d] got %b want %b", i, bus_valid, exp_grant[i] != 2'b00); end
        end
        m_req   = 2'b00;
        bus_ack = 1'b0;
        step();
    endtask

    task automatic test_read();
        m_req     = 2'b10;
        m_addr[1] = 8'h22;
        m_rnw[1]  = 1'b1;
        step();
        checks++; if (m_grant !== 2'b10 || bus_addr !== 8'h22 || bus_rnw !== 1'b1) begin
            errors++; $display("FAIL rd_bus got g=%b a=%h r=%b want 10/22/1", m_grant, bus_addr, bus_rnw); end
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        step();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        m_req     = 2'b00;
        checks++; if (m_done !== 2'b10 || m_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_capture got d=%b data=%h want 10/deadbeef", m_done, m_rdata); end
        step();
        step();
        checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold got %h want deadbeef", m_rdata); end
    endtask

    task automatic test_timeout();
        m_req      = 2'b01;
        m_addr[0]  = 8'h30;
        m_wdata[0] = 32'h0000_5555;
        m_rnw[0]   = 1'b0;
        step();
        checks++; if (m_grant !== 2'b01) begin errors++; $display("FAIL to_grant got %b want 01", m_grant); end
        for (int i = 2; i <= 64; i++) begin
            step();
            checks++; if (m_grant !== 2'b01 || m_done !== 2'b00 || m_err !== 2'b00) begin
                errors++; $display("FAIL to_busy[%0d] got g=%b d=%b e=%b want 01/00/00", i, m_grant, m_done, m_err); end
        end
        step();
        m_req = 2'b00;
        checks++; if (m_done !== 2'b01 || m_err !== 2'b01) begin errors++; $display("FAIL to_err got d=%b e=%b want 01/01", m_done, m_err); end
        checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata got %h want deadbeef", m_rdata); end
        step();
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
        step();
        step();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        checks++; if (m_done !== 2'b00 || m_err !== 2'b00 || m_grant !== 2'b00 || m_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL to_late_ack got d=%b e=%b g=%b data=%h want 00/00/00/deadbeef", m_done, m_err, m_grant, m_rdata); end
    endtask

    task automatic test_ack_at_limit();
        m_req     = 2'b10;
        m_addr[1] = 8'h44;
        m_rnw[1]  = 1'b1;
        step();
        for (int i = 2; i <= 64; i++) begin
            step();
        end
        checks++; if (m_grant !== 2'b10 || m_done !== 2'b00) begin errors++; $display("FAIL lim_busy64 got g=%b d=%b want 10/00", m_grant, m_done); end
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        step();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        m_req     = 2'b00;
        checks++; if (m_done !== 2'b10 || m_err !== 2'b00) begin errors++; $display("FAIL lim_done got d=%b e=%b want 10/00", m_done, m_err); end
        checks++; if (m_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL lim_rdata got %h want cafef00d", m_rdata); end
        step();
    endtask

    task automatic test_reset_mid_busy();
        m_req      = 2'b01;
        m_addr[0]  = 8'h55;
        m_wdata[0] = 32'h0000_00AA;
        m_rnw[0]   = 1'b0;
        step();
        step();
        step();
        checks++; if (m_grant !== 2'b01 || bus_valid !== 1'b1) begin errors++; $display("FAIL mid_busy3 got g=%b v=%b want 01/1", m_grant, bus_valid); end
        reset = 1'b0;
        step();
        checks++; if (m_grant !== 2'b00 || m_done !== 2'b00 || m_err !== 2'b00 || m_rdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset_m got g=%b d=%b e=%b data=%h want 00/00/00/0", m_grant, m_done, m_err, m_rdata); end
        checks++; if (bus_valid !== 1'b0 || bus_addr !== 8'h0 || bus_wdata !== 32'h0 || bus_rnw !== 1'b0) begin
            errors++; $display("FAIL mid_reset_bus got v=%b a=%h d=%h r=%b want all 0", bus_valid, bus_addr, bus_wdata, bus_rnw); end
        reset = 1'b1;
        m_req = 2'b11;
        step();
        checks++; if (m_grant !== 2'b01) begin errors++; $display("FAIL mid_first_grant got %b want 01", m_grant); end
        checks++; if (m_done !== 2'b00) begin errors++; $display("FAIL mid_no_done got %b want 00", m_done); end
        m_req   = 2'b00;
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++; if (m_done !== 2'b01) begin errors++; $display("FAIL mid_done got %b want 01", m_done); end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        step();
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
